// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and helpers for the ethernet receive filter
package eth_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PASS,
        FLUSH,
        DROP
    } eth_rx_state_t;

    localparam int          ETH_HDR_BYTES  = 14;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_axis_reg_slice.sv
// rtl/eth_axis_reg_slice.sv - single-stage stream register; payload held while stalled
module eth_axis_reg_slice #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready
);

    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tkeep <= s_tkeep;
                m_tlast <= s_tlast;
                m_tuser <= s_tuser;
            end
        end
    end

endmodule

// File: rtl/eth_frame_rx_filt.sv
// rtl/eth_frame_rx_filt.sv - ethernet header filter, strips the 14-byte header and forwards payload
// Define ETH_RX_SRC_CHECK_EN to also require the source MAC to equal remote_addr.
module eth_frame_rx_filt
    import eth_pkg::*;
#(
    parameter int   AXIS_DATA_WIDTH = 64,
    localparam int  AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [47:0]                local_addr,
    input  logic [47:0]                remote_addr,
    input  logic [15:0]                rx_size,
    input  logic [AXIS_DATA_WIDTH-1:0] rx_frame_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] rx_frame_tkeep,
    input  logic                       rx_frame_tvalid,
    input  logic                       rx_frame_tlast,
    input  logic                       rx_frame_tuser,
    output logic                       rx_frame_tready,
    output logic [AXIS_DATA_WIDTH-1:0] rx_orin_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] rx_orin_tkeep,
    output logic                       rx_orin_tvalid,
    output logic                       rx_orin_tlast,
    output logic                       rx_orin_tuser,
    input  logic                       rx_orin_tready,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                pass_cnt
);

    // Header bytes spilling into the second beat leave this many payload bits behind.
    localparam int RES_BITS = 8 * (2 * AXIS_KEEP_WIDTH - ETH_HDR_BYTES);

    eth_rx_state_t state, state_nxt;

    logic [AXIS_DATA_WIDTH-1:0] d;
    logic                       beat_fire;
    logic [47:0]                dst_addr;
    logic [47:0]                src_addr;
    logic [15:0]                len_field;
    logic [15:0]                src_hi;
    logic                       dst_match;
    logic                       dst_ok;
    logic                       src_ok;
    logic                       hdr_ok;
    logic [RES_BITS-1:0]        residue;
    logic [1:0]                 flush_keep;
    logic                       frame_user;
    logic [3:0]                 last_bytes;
    logic                       long_last;
    logic                       drop_inc;
    logic                       pass_inc;

    logic [AXIS_DATA_WIDTH-1:0] s_tdata;
    logic [AXIS_KEEP_WIDTH-1:0] s_tkeep;
    logic                       s_tvalid;
    logic                       s_tlast;
    logic                       s_tuser;
    logic                       s_tready;

    assign d         = rx_frame_tdata;
    assign beat_fire = rx_frame_tvalid && rx_frame_tready;

    // Byte 0 of the wire is the MSB of the MAC/length fields.
    assign dst_addr  = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    assign src_addr  = {src_hi, d[7:0], d[15:8], d[23:16], d[31:24]};
    assign len_field = {d[39:32], d[47:40]};
    assign dst_match = (dst_addr == local_addr) || (dst_addr == ETH_BCAST_ADDR);

`ifdef ETH_RX_SRC_CHECK_EN
    assign src_ok = (src_addr == remote_addr);
`else
    logic unused_src;
    assign src_ok     = 1'b1;
    assign unused_src = ^{remote_addr, src_addr};
`endif

    assign hdr_ok     = dst_ok && src_ok && (len_field == rx_size);
    assign last_bytes = keep_count(rx_frame_tkeep);
    assign long_last  = (last_bytes >= 4'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HDR0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR0: begin
                if (beat_fire && !rx_frame_tlast) state_nxt = HDR1;
            end
            HDR1: begin
                if (beat_fire) begin
                    if (rx_frame_tlast) state_nxt = HDR0;
                    else if (hdr_ok)    state_nxt = PASS;
                    else                state_nxt = DROP;
                end
            end
            PASS: begin
                if (beat_fire && rx_frame_tlast) state_nxt = long_last ? FLUSH : HDR0;
            end
            FLUSH: begin
                if (s_tready) state_nxt = HDR0;
            end
            DROP: begin
                if (beat_fire && rx_frame_tlast) state_nxt = HDR0;
            end
            default: state_nxt = HDR0;
        endcase
    end

    always_comb begin
        rx_frame_tready = 1'b1;
        s_tvalid        = 1'b0;
        s_tdata         = {d[AXIS_DATA_WIDTH-RES_BITS-1:0], residue};
        s_tkeep         = {rx_frame_tkeep[AXIS_KEEP_WIDTH-3:0], 2'b11};
        s_tlast         = 1'b0;
        s_tuser         = 1'b0;
        case (state)
            PASS: begin
                rx_frame_tready = s_tready;
                s_tvalid        = rx_frame_tvalid;
                s_tlast         = rx_frame_tlast && !long_last;
                s_tuser         = rx_frame_tlast && !long_last && (frame_user || rx_frame_tuser);
            end
            FLUSH: begin
                rx_frame_tready = 1'b0;
                s_tvalid        = 1'b1;
                s_tdata         = {{(AXIS_DATA_WIDTH-RES_BITS){1'b0}}, residue};
                s_tkeep         = {{(AXIS_KEEP_WIDTH-2){1'b0}}, flush_keep};
                s_tlast         = 1'b1;
                s_tuser         = frame_user;
            end
            default: ;
        endcase
        if (rst) rx_frame_tready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_ok     <= 1'b0;
            src_hi     <= '0;
            residue    <= '0;
            flush_keep <= '0;
            frame_user <= 1'b0;
        end else if (beat_fire) begin
            case (state)
                HDR0: begin
                    dst_ok     <= dst_match;
                    src_hi     <= {d[55:48], d[63:56]};
                    frame_user <= rx_frame_tuser;
                end
                HDR1: begin
                    residue    <= d[AXIS_DATA_WIDTH-1 -: RES_BITS];
                    frame_user <= frame_user || rx_frame_tuser;
                end
                PASS: begin
                    residue    <= d[AXIS_DATA_WIDTH-1 -: RES_BITS];
                    flush_keep <= rx_frame_tkeep[AXIS_KEEP_WIDTH-1 -: 2];
                    frame_user <= frame_user || rx_frame_tuser;
                end
                default: ;
            endcase
        end
    end

    // A tlast seen before the header decision, or while discarding, ends a dropped frame.
    assign drop_inc = beat_fire && rx_frame_tlast &&
                      (state == HDR0 || state == HDR1 || state == DROP);
    assign pass_inc = rx_orin_tvalid && rx_orin_tready && rx_orin_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            pass_cnt <= '0;
        end else begin
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (pass_inc && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end
    end

    eth_axis_reg_slice #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .KEEP_WIDTH (AXIS_KEEP_WIDTH)
    ) u_out_slice (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .s_tready (s_tready),
        .m_tdata  (rx_orin_tdata),
        .m_tkeep  (rx_orin_tkeep),
        .m_tvalid (rx_orin_tvalid),
        .m_tlast  (rx_orin_tlast),
        .m_tuser  (rx_orin_tuser),
        .m_tready (rx_orin_tready)
    );

endmodule

// File: tb/tb_eth_frame_rx_filt.sv
// tb/tb_eth_frame_rx_filt.sv - scoreboard bench for eth_frame_rx_filt
module tb_eth_frame_rx_filt;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] local_addr;
    logic [47:0] remote_addr;
    logic [15:0] rx_size;
    logic [63:0] rx_frame_tdata;
    logic [7:0]  rx_frame_tkeep;
    logic        rx_frame_tvalid;
    logic        rx_frame_tlast;
    logic        rx_frame_tuser;
    logic        rx_frame_tready;
    logic [63:0] rx_orin_tdata;
    logic [7:0]  rx_orin_tkeep;
    logic        rx_orin_tvalid;
    logic        rx_orin_tlast;
    logic        rx_orin_tuser;
    logic        rx_orin_tready;
    logic [15:0] drop_cnt;
    logic [15:0] pass_cnt;

    localparam logic [47:0] LOCAL  = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] REMOTE = 48'h1122_3344_5566;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;
    bit    bp_en    = 1'b0;
    bit    mon_en   = 1'b1;

    eth_frame_rx_filt #(.AXIS_DATA_WIDTH(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .local_addr      (local_addr),
        .remote_addr     (remote_addr),
        .rx_size         (rx_size),
        .rx_frame_tdata  (rx_frame_tdata),
        .rx_frame_tkeep  (rx_frame_tkeep),
        .rx_frame_tvalid (rx_frame_tvalid),
        .rx_frame_tlast  (rx_frame_tlast),
        .rx_frame_tuser  (rx_frame_tuser),
        .rx_frame_tready (rx_frame_tready),
        .rx_orin_tdata   (rx_orin_tdata),
        .rx_orin_tkeep   (rx_orin_tkeep),
        .rx_orin_tvalid  (rx_orin_tvalid),
        .rx_orin_tlast   (rx_orin_tlast),
        .rx_orin_tuser   (rx_orin_tuser),
        .rx_orin_tready  (rx_orin_tready),
        .drop_cnt        (drop_cnt),
        .pass_cnt        (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    initial begin
        rx_orin_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rx_orin_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst && rx_orin_tvalid && rx_orin_tready) begin
            if (sb_q.size() == 0) begin
                check("extra_beat", 64'(sb_q.size()), 64'd1);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("tdata", rx_orin_tdata & keep_mask(e.keep), e.data & keep_mask(e.keep));
                check("tkeep", 64'(rx_orin_tkeep), 64'(e.keep));
                check("tlast", 64'(rx_orin_tlast), 64'(e.last));
                check("tuser", 64'(rx_orin_tuser), 64'(e.user));
            end
        end
    end

    // plen < 0 builds a runt of 14+plen bytes; abort_at >= 0 asserts rst while driving that beat.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len,
                              input int plen, input logic [7:0] seed, input bit user_last,
                              input bit expect_ok, input int abort_at, input bit cfg_glitch);
        logic [7:0] fb[$];
        beat_t      e;
        int         nbeats;
        int         t;
        bit         acc;
        logic [47:0] saved_addr;
        logic [15:0] saved_size;
        for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
        fb.push_back(len[15:8]);
        fb.push_back(len[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(seed + 8'(i));
        while (fb.size() > 14 + plen) void'(fb.pop_back());
        nbeats = (fb.size() + 7) / 8;
        if (abort_at < 0) begin
            if (expect_ok) begin
                for (int b = 0; b * 8 < plen; b++) begin
                    e = '0;
                    for (int k = 0; k < 8 && b * 8 + k < plen; k++) begin
                        e.data[8*k +: 8] = seed + 8'(b * 8 + k);
                        e.keep[k]        = 1'b1;
                    end
                    e.last = (b * 8 + 8 >= plen);
                    e.user = e.last && user_last;
                    sb_q.push_back(e);
                end
                exp_pass++;
            end else begin
                exp_drop++;
            end
        end
        saved_addr = local_addr;
        saved_size = rx_size;
        for (int b = 0; b < nbeats; b++) begin
            if (bp_en && $urandom_range(0, 3) == 0) begin
                rx_frame_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            rx_frame_tvalid = 1'b1;
            rx_frame_tlast  = (b == nbeats - 1);
            rx_frame_tuser  = (b == nbeats - 1) && user_last;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < fb.size()) begin
                    rx_frame_tdata[8*k +: 8] = fb[b * 8 + k];
                    rx_frame_tkeep[k]        = 1'b1;
                end else begin
                    rx_frame_tdata[8*k +: 8] = 8'h00;
                    rx_frame_tkeep[k]        = 1'b0;
                end
            end
            if (b == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                check("rst_orin_tvalid", 64'(rx_orin_tvalid), 64'd0);
                check("rst_orin_tdata", rx_orin_tdata, 64'd0);
                check("rst_frame_tready", 64'(rx_frame_tready), 64'd0);
                check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
                rx_frame_tvalid = 1'b0;
                rx_frame_tlast  = 1'b0;
                rx_frame_tuser  = 1'b0;
                return;
            end
            t = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = rx_frame_tready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                check("rx_frame_tready", 64'(acc), 64'd1);
                rx_frame_tvalid = 1'b0;
                return;
            end
            if (b == 2 && expect_ok && !bp_en && abort_at < 0)
                check("latency", 64'(rx_orin_tvalid), 64'd1);
            if (b == 2 && cfg_glitch) begin
                local_addr = 48'h0000_0000_0001;
                rx_size    = ~saved_size;
            end
        end
        rx_frame_tvalid = 1'b0;
        rx_frame_tlast  = 1'b0;
        rx_frame_tuser  = 1'b0;
        local_addr      = saved_addr;
        rx_size         = saved_size;
    endtask

    task automatic drain_and_check();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || rx_orin_tvalid) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        int  plen;
        bit  good;
        rst             = 1'b1;
        local_addr      = LOCAL;
        remote_addr     = REMOTE;
        rx_size         = 16'h0010;
        rx_frame_tdata  = '0;
        rx_frame_tkeep  = '0;
        rx_frame_tvalid = 1'b0;
        rx_frame_tlast  = 1'b0;
        rx_frame_tuser  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_frame_tready", 64'(rx_frame_tready), 64'd0);
        check("reset_orin_tvalid", 64'(rx_orin_tvalid), 64'd0);
        check("reset_pass_cnt", 64'(pass_cnt), 64'd0);
        check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_frame(LOCAL, REMOTE, 16'h0010, 16, 8'h00, 0, 1, -1, 0);        drain_and_check();
        send_frame(48'h0A0B_0C0D_0E00, REMOTE, 16'h0010, 16, 8'h00, 0, 0, -1, 0); drain_and_check();
        send_frame(48'hFFFF_FFFF_FFFF, REMOTE, 16'h0010, 16, 8'h40, 0, 1, -1, 0); drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0011, 16, 8'h00, 0, 0, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, -4, 8'h00, 0, 0, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 2, 8'h00, 0, 0, -1, 0);         drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 3, 8'h80, 0, 1, -1, 0);         drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 24, 8'h10, 0, 1, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 25, 8'h20, 1, 1, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 26, 8'h30, 0, 1, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 20, 8'h50, 1, 1, -1, 0);        drain_and_check();
        send_frame(LOCAL, REMOTE, 16'h0010, 30, 8'h60, 0, 1, -1, 1);        drain_and_check();

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            plen = $urandom_range(3, 40);
            good = ($urandom_range(0, 3) != 0);
            send_frame(good ? LOCAL : 48'h0A0B_0C0D_0E01, REMOTE, 16'h0010, plen,
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), good, -1, 0);
        end
        drain_and_check();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

`ifdef ETH_RX_SRC_CHECK_EN
        send_frame(LOCAL, 48'h1122_3344_5567, 16'h0010, 16, 8'h70, 0, 0, -1, 0);
`else
        send_frame(LOCAL, 48'h1122_3344_5567, 16'h0010, 16, 8'h70, 0, 1, -1, 0);
`endif
        drain_and_check();

        mon_en = 1'b0;
        send_frame(LOCAL, REMOTE, 16'h0010, 30, 8'h90, 0, 1, 3, 0);
        sb_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_frame(LOCAL, REMOTE, 16'h0010, 17, 8'hA0, 1, 1, -1, 0);        drain_and_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
